// File: rtl/scan_pkg.sv
// Shared constants and helpers for the scan-locked slot arbiter.
package scan_pkg;

    localparam logic PHASE_DISP = 1'b0;
    localparam logic PHASE_FREE = 1'b1;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_BUDGET  = 8;
    localparam int DEF_CNT_W   = $clog2(DEF_BUDGET + 1);

    // Counter must hold 0..budget inclusive so it can saturate without wrapping.
    function automatic int cnt_width(input int budget);
        return $clog2(budget + 1);
    endfunction

endpackage

// File: rtl/scan_slot_arbiter_rr_pick.sv
// Round-robin picker: first set bit at or after ptr, wrapping, via a doubled vector.
module rr_pick
    import scan_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] dbl;

    always_comb begin
        dbl   = {req, req} >> ptr;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Descending scan so the lowest offset from ptr wins.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                valid = 1'b1;
                idx   = PW'((int'(ptr) + j) % NUM_REQ);
            end
        end
        if (valid) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/scan_slot_arbiter.sv
// Memory-slot arbiter locked to raster timing: display owns even active slots,
// background requesters share the rest round-robin under a per-line budget.
module scan_slot_arbiter
    import scan_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int BUDGET  = DEF_BUDGET
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               x_active,
    input  logic               y_active,
    input  logic               new_line,
    input  logic               new_frame,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_disp,
    output logic [NUM_REQ-1:0] starved,
    output logic               phase
);

    localparam int CNT_W = cnt_width(BUDGET);
    localparam int PW    = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [CNT_W-1:0]   count [NUM_REQ];
    logic [NUM_REQ-1:0] seen, granted;
    logic [NUM_REQ-1:0] eligible, pick_gnt, line_starve;
    logic [PW-1:0]      pick_idx;
    logic               pick_valid, open;

    assign gnt_disp = en && x_active && y_active && (phase == PHASE_DISP);
    assign open     = en && !gnt_disp && !reset;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req[i] && (count[i] < CNT_W'(BUDGET));
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign gnt = open ? pick_gnt : '0;

    // A grant in the boundary cycle still belongs to the line that is ending.
    assign line_starve = (seen | (req & {NUM_REQ{open}})) & ~(granted | gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= PHASE_DISP;
            rr_ptr  <= '0;
            seen    <= '0;
            granted <= '0;
            starved <= '0;
            for (int i = 0; i < NUM_REQ; i++) count[i] <= '0;
        end else if (en) begin
            phase <= new_line ? PHASE_DISP : ~phase;
            if (open && pick_valid)
                rr_ptr <= (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (new_line) begin
                seen    <= '0;
                granted <= '0;
                for (int i = 0; i < NUM_REQ; i++) count[i] <= '0;
                starved <= (new_frame ? '0 : starved) | line_starve;
            end else begin
                seen    <= seen | (req & {NUM_REQ{open}});
                granted <= granted | gnt;
                if (new_frame) starved <= '0;
                for (int i = 0; i < NUM_REQ; i++)
                    if (gnt[i] && count[i] != CNT_W'(BUDGET)) count[i] <= count[i] + 1'b1;
            end
        end
    end

endmodule
